vluint7_enc: RTL and testbench

VLUINT7_ENC -- requirements
Module: vluint7_enc

---
 rtl/vluint7_enc.sv | 133 +++++++++++++
 tb/tb_vluint7_enc.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vluint7_enc.sv
// vluint7_enc: encodes one unsigned value per request as a LEB128-style
// little-endian varint (7 payload bits per byte, bit 7 = continuation) and
// writes the bytes to consecutive memory addresses with a ready handshake.
// Optional build macro: VLUINT7_ZIGZAG_EN -- zigzag-maps the input as a signed
// two's-complement value before encoding, so small negatives stay short.
// Width macros MEM_ADDR_WIDTH / INSTR_WIDTH / MEM_DATA_WIDTH default below
// when the surrounding project does not define them.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 16
`endif

module vluint7_enc (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       beg,
   input  logic [`MEM_ADDR_WIDTH-1:0] addr,
   input  logic [`INSTR_WIDTH-1:0]    data,
   input  logic                       mem_ready,
   output logic [`MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [`MEM_DATA_WIDTH-1:0] mem_wdata,
   output logic                       mem_we,
   output logic                       busy,
   output logic                       rd,
   output logic [`MEM_ADDR_WIDTH-1:0] addr_out,
   output logic [3:0]                 nbytes
);

   localparam int AW = `MEM_ADDR_WIDTH;
   localparam int IW = `INSTR_WIDTH;
   localparam int DW = `MEM_DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   rem_reg, rem_next;          // value bits not yet written
   logic [AW-1:0]   addr_reg, addr_next;        // address of the byte on the bus
   logic [3:0]      count_reg, count_next;      // bytes accepted so far
   logic [AW-1:0]   addr_out_reg, addr_out_next;
   logic [3:0]      nbytes_reg, nbytes_next;

   logic [IW-1:0]   value_in;
   logic            cont;
   logic [7:0]      enc_byte;

`ifdef VLUINT7_ZIGZAG_EN
   // (d << 1) ^ (d >>> (IW-1)): the arithmetic shift is just the sign bit
   // replicated, built explicitly so no signedness context can turn it logical.
   logic [IW-1:0]   sign_fill;
   assign sign_fill = {IW{data[IW-1]}};
   assign value_in  = {data[IW-2:0], 1'b0} ^ sign_fill;
`else
   assign value_in  = data;
`endif

   // The byte on the bus is derived from the remaining value, so it cannot
   // change while a write is stalled (rem_reg only moves on acceptance).
   assign cont      = |rem_reg[IW-1:7];
   assign enc_byte  = {cont, rem_reg[6:0]};
   assign mem_wdata = DW'(enc_byte);
   assign mem_addr  = addr_reg;
   assign addr_out  = addr_out_reg;
   assign nbytes    = nbytes_reg;

   // Next-state and output decode; everything holds unless a case updates it.
   always_comb begin
      state_next    = state_reg;
      rem_next      = rem_reg;
      addr_next     = addr_reg;
      count_next    = count_reg;
      addr_out_next = addr_out_reg;
      nbytes_next   = nbytes_reg;
      mem_we        = 1'b0;
      busy          = 1'b0;
      rd            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (beg) begin
               state_next = EMIT;
               rem_next   = value_in;
               addr_next  = addr;
               count_next = 4'd0;
            end
         end
         EMIT: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            if (mem_ready) begin
               rem_next   = rem_reg >> 7;
               addr_next  = addr_reg + AW'(1);
               count_next = count_reg + 4'd1;
               // No higher bits left: this byte was the last one.
               if (!cont) begin
                  state_next    = DONE;
                  addr_out_next = addr_reg + AW'(1);
                  nbytes_next   = count_reg + 4'd1;
               end
            end
         end
         DONE: begin
            rd         = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with synchronous active-low reset (wins over beg).
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         rem_reg      <= '0;
         addr_reg     <= '0;
         count_reg    <= '0;
         addr_out_reg <= '0;
         nbytes_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         rem_reg      <= rem_next;
         addr_reg     <= addr_next;
         count_reg    <= count_next;
         addr_out_reg <= addr_out_next;
         nbytes_reg   <= nbytes_next;
      end
   end

endmodule

// File: tb/tb_vluint7_enc.sv
// tb_vluint7_enc: directed and randomized encodes of vluint7_enc checked
// against an arithmetic varint model (divide/modulo by 128), with a bus
// monitor recording every accepted write.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 16
`endif

module tb_vluint7_enc;

   localparam int AW = `MEM_ADDR_WIDTH;
   localparam int IW = `INSTR_WIDTH;
   localparam int DW = `MEM_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          reset, beg, mem_ready;
   logic [AW-1:0] addr;
   logic [IW-1:0] data;
   logic [AW-1:0] mem_addr, addr_out;
   logic [DW-1:0] mem_wdata;
   logic          mem_we, busy, rd;
   logic [3:0]    nbytes;

   int compared   = 0;
   int mismatched = 0;

   vluint7_enc dut (
      .clk(clk), .reset(reset), .beg(beg), .addr(addr), .data(data),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .busy(busy), .rd(rd), .addr_out(addr_out),
      .nbytes(nbytes)
   );

   always #5 clk = ~clk;

   // Bus monitor (negedge, inputs and outputs settled)
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            rd_cnt   = 0;
   int            hold_bad = 0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_a;
   logic [DW-1:0] prev_d;

   always @(negedge clk) begin
      if (mem_we === 1'b1 && mem_ready === 1'b1) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
      if (rd === 1'b1) rd_cnt++;
      if (prev_stall && reset === 1'b1 &&
          (mem_we !== 1'b1 || mem_addr !== prev_a || mem_wdata !== prev_d))
         hold_bad++;
      prev_stall = (mem_we === 1'b1 && mem_ready === 1'b0 && reset === 1'b1);
      prev_a     = mem_addr;
      prev_d     = mem_wdata;
   end

   // Reference model
   logic [7:0] exp_b[$];

   function automatic logic [IW-1:0] map_val(input logic [IW-1:0] d);
`ifdef VLUINT7_ZIGZAG_EN
      longint m = longint'(1) << IW;
      longint u = longint'(d);
      if (d[IW-1]) return IW'(2 * (m - u) - 1);   // negative n -> 2|n|-1
      else         return IW'(2 * u);             // non-negative n -> 2n
`else
      return d;
`endif
   endfunction

   task automatic build_exp(input logic [IW-1:0] val);
      longint v = longint'(val);
      logic [7:0] b;
      exp_b.delete();
      do begin
         b = 8'(v % 128);
         v = v / 128;
         if (v != 0) b = b + 8'd128;
         exp_b.push_back(b);
      end while (v != 0);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One encode; stall = cycles mem_ready is held low on the first byte,
   // rnd = random mem_ready every cycle, poke = pulse beg while busy.
   task automatic run_enc(input string tag, input logic [AW-1:0] a, input logic [IW-1:0] d,
                          input int stall, input bit rnd, input bit poke);
      int cyc;
      bit seen;
      longint dec;
      logic [AW-1:0] ea;
      build_exp(map_val(d));
      wa_q.delete();
      wd_q.delete();
      rd_cnt = 0;
      beg = 1'b1; addr = a; data = d;
      @(posedge clk); #1;
      beg = 1'b0; addr = AW'($urandom); data = IW'($urandom);
      cyc = 1; seen = 1'b0;
      chk({tag, ".busy1"}, 64'(busy), 64'd1);
      chk({tag, ".addr1"}, 64'(mem_addr), 64'(a));
      while (!seen && cyc < 80) begin
         if (rd === 1'b1) begin
            seen = 1'b1;
         end else begin
            mem_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc > stall);
            if (poke) beg = (cyc == 2);
            if (!rnd && stall > 0 && cyc == stall)
               chk({tag, ".stall_byte"}, 64'(mem_wdata), 64'(exp_b[0]));
            @(posedge clk); #1;
            cyc++;
         end
      end
      beg = 1'b0; mem_ready = 1'b1;
      chk({tag, ".rd_seen"}, 64'(seen), 64'd1);
      if (!rnd) chk({tag, ".latency"}, 64'(cyc), 64'(exp_b.size() + 1 + stall));
      chk({tag, ".busy_rd"}, 64'(busy), 64'd0);
      chk({tag, ".we_rd"}, 64'(mem_we), 64'd0);
      chk({tag, ".nbytes"}, 64'(nbytes), 64'(exp_b.size()));
      ea = a + AW'(exp_b.size());
      chk({tag, ".addr_out"}, 64'(addr_out), 64'(ea));
      chk({tag, ".nwrites"}, 64'(wd_q.size()), 64'(exp_b.size()));
      dec = 0;
      for (int i = 0; i < exp_b.size() && i < wd_q.size(); i++) begin
         chk($sformatf("%s.byte%0d", tag, i), 64'(wd_q[i]), 64'(exp_b[i]));
         chk($sformatf("%s.waddr%0d", tag, i), 64'(wa_q[i]), 64'(AW'(a + AW'(i))));
         dec = dec | (longint'(wd_q[i] & 16'h7F) << (7 * i));
      end
      chk({tag, ".roundtrip"}, 64'(dec), 64'(map_val(d)));
      @(posedge clk); #1;
      chk({tag, ".rd_once"}, 64'(rd_cnt), 64'd1);
      chk({tag, ".addr_out_held"}, 64'(addr_out), 64'(ea));
      chk({tag, ".idle_we"}, 64'(mem_we), 64'd0);
      $display("enc %s addr=0x%0h data=0x%0h nbytes=%0d latency=%0d", tag, a, d, nbytes, cyc);
   endtask

   initial begin
      reset = 1'b0; beg = 1'b1; mem_ready = 1'b1; addr = 'h33; data = 'h1234;
      // reset asserted together with beg: reset wins
      repeat (2) @(posedge clk);
      #1;
      chk("rst.we", 64'(mem_we), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.rd", 64'(rd), 64'd0);
      chk("rst.mem_addr", 64'(mem_addr), 64'd0);
      chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst.addr_out", 64'(addr_out), 64'd0);
      chk("rst.nbytes", 64'(nbytes), 64'd0);
      beg = 1'b0; reset = 1'b1;
      @(posedge clk); #1;

      run_enc("zero", AW'('h10), IW'(0), 0, 1'b0, 1'b0);
      run_enc("d127", AW'('h40), IW'(127), 0, 1'b0, 1'b0);
      run_enc("d128", AW'('h50), IW'(128), 0, 1'b0, 1'b0);
      run_enc("d300", AW'('h60), IW'(300), 0, 1'b0, 1'b0);
`ifndef VLUINT7_ZIGZAG_EN
      chk("d300.const0", 64'(wd_q[0]), 64'h00AC);
      chk("d300.const1", 64'(wd_q[1]), 64'h0002);
`endif
      run_enc("dmax", AW'('h100), IW'('hFFFF_FFFF), 0, 1'b0, 1'b0);
`ifndef VLUINT7_ZIGZAG_EN
      chk("dmax.const4", 64'(wd_q[4]), 64'h000F);
`endif
      run_enc("stall", AW'('h70), IW'(300), 3, 1'b0, 1'b1);
      chk("stall.hold", 64'(hold_bad), 64'd0);

      // reset in the middle of a two-byte encode, second byte stalled
      rd_cnt = 0;
      beg = 1'b1; addr = AW'('h20); data = IW'(128);
      @(posedge clk); #1;
      beg = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      chk("abort.we2", 64'(mem_we), 64'd1);
      chk("abort.addr2", 64'(mem_addr), 64'h21);
      mem_ready = 1'b0; reset = 1'b0;
      @(posedge clk); #1;
      chk("abort.we", 64'(mem_we), 64'd0);
      chk("abort.busy", 64'(busy), 64'd0);
      chk("abort.mem_addr", 64'(mem_addr), 64'd0);
      reset = 1'b1; mem_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort.no_rd", 64'(rd_cnt), 64'd0);
      chk("abort.idle_we", 64'(mem_we), 64'd0);
      $display("enc abort addr=0x20 data=0x80 reset during byte 1");

      run_enc("wrap", {AW{1'b1}}, IW'(300), 0, 1'b0, 1'b0);

`ifdef VLUINT7_ZIGZAG_EN
      run_enc("zz_m1", AW'('h200), IW'(-1), 0, 1'b0, 1'b0);
      chk("zz_m1.const", 64'(wd_q[0]), 64'h0001);
      run_enc("zz_p1", AW'('h210), IW'(1), 0, 1'b0, 1'b0);
      chk("zz_p1.const", 64'(wd_q[0]), 64'h0002);
      run_enc("zz_m65", AW'('h220), IW'(-65), 0, 1'b0, 1'b0);
      chk("zz_m65.const0", 64'(wd_q[0]), 64'h0081);
      chk("zz_m65.const1", 64'(wd_q[1]), 64'h0001);
`endif

      for (int n = 0; n < 20; n++) begin
         logic [IW-1:0] rv;
         rv = IW'($urandom) >> $urandom_range(0, IW - 1);
         run_enc($sformatf("rnd%0d", n), AW'($urandom), rv, 0, 1'b1, 1'b0);
      end
      chk("final.hold", 64'(hold_bad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
